// File: rtl/pause_pkg.sv
// ---------------------------------------------------------------------------
// pause_pkg : shared state encoding and default timing constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pause_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    PAUSED   = 2'd1,
    RESUMING = 2'd2
  } pause_state_t;

  localparam int DEF_DB_CYCLES     = 1_000_000;
  localparam int DEF_BLINK_FRAMES  = 30;
  localparam int DEF_RESUME_FRAMES = 60;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce : two-flop synchroniser, counting debouncer, rising-edge press
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_debounce
  import pause_pkg::*;
#(
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          db;
  logic          db_q;
  logic [CW-1:0] cnt;

  // Synchroniser keeps sampling through reset so db can load the held level.
  always_ff @(posedge clk) begin
    s1 <= btn;
    s2 <= s1;
  end

  // Loading db and db_q from s2 in reset stops a held button from pausing.
  always_ff @(posedge clk) begin
    if (rst) begin
      db   <= s2;
      db_q <= s2;
      cnt  <= '0;
    end else begin
      db_q <= db;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= ~db;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = db;
  assign press = db & ~db_q;

endmodule

`default_nettype wire

// File: rtl/pause_ctrl.sv
// ---------------------------------------------------------------------------
// pause_ctrl : RUN / PAUSED / RESUMING controller with blinking overlay enable
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pause_ctrl
  import pause_pkg::*;
#(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int BLINK_FRAMES  = DEF_BLINK_FRAMES,
  parameter int RESUME_FRAMES = DEF_RESUME_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause,
  input  logic       frame_tick,
  input  logic       game_active,
  output logic       paused,
  output logic       text_en,
  output logic [1:0] state_o
);

  localparam int FW = $clog2(max_int(BLINK_FRAMES, RESUME_FRAMES) + 1);
  localparam logic [FW-1:0] BLINK_LAST  = FW'(BLINK_FRAMES - 1);
  localparam logic [FW-1:0] RESUME_LAST = FW'(RESUME_FRAMES - 1);
  localparam logic [FW-1:0] CNT_MAX     = '1;

  pause_state_t  state;
  pause_state_t  nxt_state;
  logic [FW-1:0] cnt;
  logic [FW-1:0] nxt_cnt;
  logic          blink_ph;
  logic          nxt_blink;
  logic          press;
  logic          db_level_unused;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn_pause),
    .level(db_level_unused),
    .press(press)
  );

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_blink = blink_ph;

    if (!game_active) begin
      nxt_state = RUN;
    end else begin
      case (state)
        RUN:      if (press) nxt_state = PAUSED;
        PAUSED:   if (press) nxt_state = RESUMING;
        RESUMING: begin
          if (press)
            nxt_state = PAUSED;
          else if (frame_tick && (cnt >= RESUME_LAST))
            nxt_state = RUN;
        end
        default:  nxt_state = RUN;
      endcase
    end

    // A state change swallows any coincident frame tick.
    if (nxt_state != state) begin
      nxt_cnt = '0;
      if (nxt_state == PAUSED)
        nxt_blink = 1'b1;
    end else if (frame_tick) begin
      if ((state == PAUSED) && (cnt >= BLINK_LAST)) begin
        nxt_cnt   = '0;
        nxt_blink = ~blink_ph;
      end else if (cnt != CNT_MAX) begin
        nxt_cnt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= '0;
      blink_ph <= 1'b0;
      paused   <= 1'b0;
      text_en  <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      blink_ph <= nxt_blink;
      paused   <= (nxt_state != RUN);
      text_en  <= (nxt_state == PAUSED) && nxt_blink;
    end
  end

  assign state_o = state;

endmodule

`default_nettype wire

// File: tb/tb_pause_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pause_ctrl : self-checking bench for pause_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_pause_ctrl;

  localparam int DB = 4;
  localparam int BF = 2;
  localparam int RF = 3;

  localparam int ACT_TICK  = 0;
  localparam int ACT_PRESS = 1;
  localparam int ACT_DROP  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_pause = 1'b0;
  logic       frame_tick = 1'b0;
  logic       game_active = 1'b1;
  logic       paused;
  logic       text_en;
  logic [1:0] state_o;

  pause_ctrl #(
    .DB_CYCLES    (DB),
    .BLINK_FRAMES (BF),
    .RESUME_FRAMES(RF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_pause  (btn_pause),
    .frame_tick (frame_tick),
    .game_active(game_active),
    .paused     (paused),
    .text_en    (text_en),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       p;
    logic       t;
    logic [1:0] s;
  } exp_t;

  typedef struct {
    int         act;
    logic       p;
    logic       t;
    logic [1:0] s;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic sb_push(input string name, input logic p, input logic t, input logic [1:0] s);
    exp_t e;
    e.name = name;
    e.p    = p;
    e.t    = t;
    e.s    = s;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      n_miss++;
      $display("FAIL scoreboard: no expected entry queued");
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if (paused !== e.p || text_en !== e.t || state_o !== e.s) begin
      n_miss++;
      $display("FAIL %s: got paused=%0b text_en=%0b state=%0d, expected paused=%0b text_en=%0b state=%0d",
               e.name, paused, text_en, state_o, e.p, e.t, e.s);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_btn();
    btn_pause = 1'b1;
    edges(7);
    btn_pause = 1'b0;
    edges(8);
  endtask

  task automatic frame();
    edges(9);
    frame_tick = 1'b1;
    edges(1);
    frame_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Entered in PAUSED with blink phase 1 and frame counter 0.
    tbl.push_back('{ACT_TICK,  1'b1, 1'b1, 2'd1});
    tbl.push_back('{ACT_TICK,  1'b1, 1'b0, 2'd1});
    tbl.push_back('{ACT_TICK,  1'b1, 1'b0, 2'd1});
    tbl.push_back('{ACT_TICK,  1'b1, 1'b1, 2'd1});
    tbl.push_back('{ACT_TICK,  1'b1, 1'b1, 2'd1});
    tbl.push_back('{ACT_PRESS, 1'b1, 1'b0, 2'd2});
    tbl.push_back('{ACT_TICK,  1'b1, 1'b0, 2'd2});
    tbl.push_back('{ACT_TICK,  1'b1, 1'b0, 2'd2});
    tbl.push_back('{ACT_TICK,  1'b0, 1'b0, 2'd0});
    tbl.push_back('{ACT_PRESS, 1'b1, 1'b1, 2'd1});
    tbl.push_back('{ACT_PRESS, 1'b1, 1'b0, 2'd2});
    tbl.push_back('{ACT_TICK,  1'b1, 1'b0, 2'd2});
    tbl.push_back('{ACT_PRESS, 1'b1, 1'b1, 2'd1});
    tbl.push_back('{ACT_TICK,  1'b1, 1'b1, 2'd1});
    tbl.push_back('{ACT_TICK,  1'b1, 1'b0, 2'd1});
    tbl.push_back('{ACT_DROP,  1'b0, 1'b0, 2'd0});
    tbl.push_back('{ACT_PRESS, 1'b1, 1'b1, 2'd1});
    tbl.push_back('{ACT_DROP,  1'b0, 1'b0, 2'd0});

    // Reset
    rst = 1'b1;
    edges(5);
    rst = 1'b0;
    sb_push("reset", 1'b0, 1'b0, 2'd0);
    edges(1);
    check_out();

    // Clean press: effect lands exactly at edge DB+2
    btn_pause = 1'b1;
    sb_push("press_edge5", 1'b0, 1'b0, 2'd0);
    edges(6);
    check_out();
    sb_push("press_edge6", 1'b1, 1'b1, 2'd1);
    edges(1);
    check_out();
    btn_pause = 1'b0;
    edges(8);

    // Table of frame-level actions
    for (int i = 0; i < tbl.size(); i++) begin
      sb_push($sformatf("vec%0d", i), tbl[i].p, tbl[i].t, tbl[i].s);
      case (tbl[i].act)
        ACT_TICK:  frame();
        ACT_PRESS: press_btn();
        default: begin
          game_active = 1'b0;
          edges(1);
          game_active = 1'b1;
        end
      endcase
      check_out();
    end

    // Press and frame tick on the same edge: tick must not count in RESUMING
    sb_push("re_pause", 1'b1, 1'b1, 2'd1);
    press_btn();
    check_out();
    sb_push("pause_tick", 1'b1, 1'b1, 2'd1);
    frame();
    check_out();
    btn_pause = 1'b1;
    edges(6);
    frame_tick = 1'b1;
    sb_push("press_with_tick", 1'b1, 1'b0, 2'd2);
    edges(1);
    frame_tick = 1'b0;
    check_out();
    btn_pause = 1'b0;
    edges(8);
    sb_push("resume_tick1", 1'b1, 1'b0, 2'd2);
    frame();
    check_out();
    sb_push("resume_tick2", 1'b1, 1'b0, 2'd2);
    frame();
    check_out();
    sb_push("resume_tick3", 1'b0, 1'b0, 2'd0);
    frame();
    check_out();

    // Glitch rejection
    btn_pause = 1'b1;
    edges(3);
    btn_pause = 1'b0;
    sb_push("glitch3", 1'b0, 1'b0, 2'd0);
    edges(12);
    check_out();
    btn_pause = 1'b1;
    edges(4);
    btn_pause = 1'b0;
    sb_push("pulse4", 1'b1, 1'b1, 2'd1);
    edges(12);
    check_out();

    // Reset mid-operation with the button held through it
    btn_pause = 1'b1;
    rst = 1'b1;
    sb_push("rst_midop", 1'b0, 1'b0, 2'd0);
    edges(1);
    check_out();
    edges(4);
    rst = 1'b0;
    sb_push("held_thru_rst", 1'b0, 1'b0, 2'd0);
    edges(12);
    check_out();
    btn_pause = 1'b0;
    sb_push("release_no_press", 1'b0, 1'b0, 2'd0);
    edges(10);
    check_out();
    sb_push("repress", 1'b1, 1'b1, 2'd1);
    press_btn();
    check_out();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
